// File: rtl/traffic_pkg.sv
// traffic_pkg: lamp codes and phase state encoding shared by the intersection scheduler
package traffic_pkg;
    localparam logic [1:0] RED = 2'b00, GREEN = 2'b01, YELLOW = 2'b10;
    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        EW_G = 3'd3,
        EW_Y = 3'd4,
        WALK = 3'd5,
        AR2  = 3'd6
    } phase_t;
endpackage

// File: rtl/phase_timer.sv
// phase_timer: saturating phase counter with sync clear and duration-expired compare
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] dur,
    output logic [CNT_W-1:0] count,
    output logic             expired
);
    assign expired = count >= dur - 1'b1;
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (clr) count <= '0;
        else if (count != '1) count <= count + 1'b1;
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: timed N/S, E/W and pedestrian phase sequencer with registered lamp decode
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 20,
    parameter int GREEN_MAX = 60,
    parameter int YELLOW_T  = 5,
    parameter int ALLRED_T  = 2,
    parameter int WALK_T    = 15,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_ew,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);
    phase_t state, nxt;
    logic [CNT_W-1:0] count, dur;
    logic expired, clr;
    // E/W green stretches to the max cap only while a car is still waiting
    always_comb
        dur = (state == NS_G) ? CNT_W'(GREEN_MIN) :
              (state == EW_G) ? (car_ew ? CNT_W'(GREEN_MAX) : CNT_W'(GREEN_MIN)) :
              (state == NS_Y || state == EW_Y) ? CNT_W'(YELLOW_T) :
              (state == WALK) ? CNT_W'(WALK_T) : CNT_W'(ALLRED_T);
    always_comb begin
        nxt = AR2;
        case (state)
            NS_G:    nxt = (expired && (car_ew || ped_pending)) ? NS_Y : NS_G;
            NS_Y:    nxt = expired ? AR1 : NS_Y;
            AR1:     nxt = expired ? (ped_pending ? WALK : EW_G) : AR1;
            EW_G:    nxt = expired ? EW_Y : EW_G;
            EW_Y:    nxt = expired ? AR2 : EW_Y;
            WALK:    nxt = expired ? AR2 : WALK;
            AR2:     nxt = expired ? NS_G : AR2;
            default: nxt = AR2;
        endcase
    end
    assign clr = nxt != state;
    assign phase = state;
    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk(clk), .reset(reset), .clr(clr), .dur(dur), .count(count), .expired(expired)
    );
    // lamps decode the next state so they switch together with the state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= AR2;
            ns_light    <= RED;
            ew_light    <= RED;
            walk        <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state       <= nxt;
            ns_light    <= (nxt == NS_G) ? GREEN : (nxt == NS_Y) ? YELLOW : RED;
            ew_light    <= (nxt == EW_G) ? GREEN : (nxt == EW_Y) ? YELLOW : RED;
            walk        <= nxt == WALK;
            ped_pending <= (state == AR1 && expired && ped_pending) ? 1'b0 :
                           (ped_req && state != WALK) ? 1'b1 : ped_pending;
        end
    end
endmodule
